// File: rtl/axis_uart_bridge_rx_tx.sv
// Full-duplex AXI-Stream <-> UART 8N1 bridge: a TX word queue feeding a byte
// serialiser, and an RX deserialiser assembling words into a queue.
module axis_uart_bridge_rx_tx #(
  parameter int unsigned UART_SPEED      = 115200,
  parameter int unsigned FREQ_HZ         = 100000000,
  parameter int unsigned N_BYTES         = 32,
  parameter int unsigned QUEUE_DEPTH     = 32,
  parameter string       QUEUE_MEMTYPE   = "auto",
  parameter int unsigned TX_REGISTER_LEN = 1,
  parameter int unsigned RX_REGISTER_LEN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BYTES*8-1:0] S_AXIS_TDATA,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  output logic [N_BYTES*8-1:0] M_AXIS_TDATA,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  input  logic                 UART_RX,
  output logic                 UART_TX
);

  localparam int unsigned BIT     = FREQ_HZ / UART_SPEED;
  localparam int unsigned HALF    = BIT / 2;
  localparam int unsigned BAUD_W  = $clog2(BIT);
  localparam int unsigned PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned BC_W    = $clog2(N_BYTES + 1);
  localparam int unsigned W       = N_BYTES * 8;
  localparam int unsigned RX_PIPE = 2 + RX_REGISTER_LEN;

  // The memory-style hint only selects an implementation; reject unknown values early.
  localparam bit MEMTYPE_OK = (QUEUE_MEMTYPE == "auto") || (QUEUE_MEMTYPE == "block") ||
                              (QUEUE_MEMTYPE == "distributed") || (QUEUE_MEMTYPE == "ultra");

  if (!MEMTYPE_OK || (FREQ_HZ < 4 * UART_SPEED) || (N_BYTES < 1) || (QUEUE_DEPTH < 2))
  begin : g_param_check
    $error("axis_uart_bridge_rx_tx: illegal parameter set");
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------- TX queue ----------------
  logic [W-1:0]     tx_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] tx_wr, tx_rd;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n_c;
  logic             tx_ready;
  logic             tx_push_c, tx_pop_c, tx_empty_c;

  assign tx_push_c     = S_AXIS_TVALID && tx_ready;
  assign tx_empty_c    = (tx_cnt == '0);
  assign tx_cnt_n_c    = tx_cnt + CNT_W'(tx_push_c) - CNT_W'(tx_pop_c);
  assign S_AXIS_TREADY = tx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_cnt   <= '0;
      tx_ready <= 1'b0;
    end else begin
      if (tx_push_c) tx_wr <= ptr_inc(tx_wr);
      if (tx_pop_c)  tx_rd <= ptr_inc(tx_rd);
      tx_cnt   <= tx_cnt_n_c;
      tx_ready <= (tx_cnt_n_c != CNT_W'(QUEUE_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push_c) tx_mem[tx_wr] <= S_AXIS_TDATA;
  end

  // ---------------- TX serialiser ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t        tx_state, tx_state_n;
  logic [BAUD_W-1:0] tx_baud, tx_baud_n;
  logic [2:0]       tx_bit_idx, tx_bit_idx_n;
  logic [BC_W-1:0]  tx_byte_idx, tx_byte_idx_n;
  logic [W-1:0]     tx_shift, tx_shift_n;
  logic             tx_bit, tx_bit_n;
  logic             tx_load_c, tx_bit_end_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tx_baud     <= '0;
      tx_bit_idx  <= '0;
      tx_byte_idx <= '0;
      tx_shift    <= '0;
      tx_bit      <= 1'b1;
    end else begin
      tx_state    <= tx_state_n;
      tx_baud     <= tx_baud_n;
      tx_bit_idx  <= tx_bit_idx_n;
      tx_byte_idx <= tx_byte_idx_n;
      tx_shift    <= tx_shift_n;
      tx_bit      <= tx_bit_n;
    end
  end

  // A load at the end of the last stop bit keeps consecutive words gapless.
  always_comb begin
    tx_state_n    = tx_state;
    tx_baud_n     = tx_baud;
    tx_bit_idx_n  = tx_bit_idx;
    tx_byte_idx_n = tx_byte_idx;
    tx_shift_n    = tx_shift;
    tx_bit_n      = tx_bit;
    tx_pop_c      = 1'b0;
    tx_load_c     = 1'b0;
    tx_bit_end_c  = (tx_baud == BAUD_W'(BIT - 1));
    case (tx_state)
      TX_IDLE: begin
        tx_bit_n = 1'b1;
        if (!tx_empty_c) tx_state_n = TX_LOAD;
      end
      TX_LOAD: tx_load_c = 1'b1;
      TX_START: begin
        if (tx_bit_end_c) begin
          tx_baud_n    = '0;
          tx_bit_idx_n = '0;
          tx_bit_n     = tx_shift[0];
          tx_state_n   = TX_DATA;
        end else begin
          tx_baud_n = tx_baud + BAUD_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_bit_end_c) begin
          tx_baud_n  = '0;
          tx_shift_n = tx_shift >> 1;
          if (tx_bit_idx == 3'd7) begin
            tx_bit_n   = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_bit_idx_n = tx_bit_idx + 3'd1;
            tx_bit_n     = tx_shift[1];
          end
        end else begin
          tx_baud_n = tx_baud + BAUD_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_bit_end_c) begin
          tx_baud_n = '0;
          if (tx_byte_idx == BC_W'(N_BYTES - 1)) begin
            if (!tx_empty_c) tx_load_c = 1'b1;
            else             tx_state_n = TX_IDLE;
          end else begin
            tx_byte_idx_n = tx_byte_idx + BC_W'(1);
            tx_bit_n      = 1'b0;
            tx_state_n    = TX_START;
          end
        end else begin
          tx_baud_n = tx_baud + BAUD_W'(1);
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (tx_load_c) begin
      tx_pop_c      = 1'b1;
      tx_shift_n    = tx_mem[tx_rd];
      tx_byte_idx_n = '0;
      tx_baud_n     = '0;
      tx_bit_n      = 1'b0;
      tx_state_n    = TX_START;
    end
  end

  if (TX_REGISTER_LEN == 0) begin : g_tx_direct
    assign UART_TX = tx_bit;
  end else begin : g_tx_pipe
    logic [TX_REGISTER_LEN-1:0] tx_pipe;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) tx_pipe <= '1;
      else       tx_pipe <= TX_REGISTER_LEN'({tx_pipe, tx_bit});
    end
    assign UART_TX = tx_pipe[TX_REGISTER_LEN-1];
  end

  // ---------------- RX synchroniser and deserialiser ----------------
  logic [RX_PIPE-1:0] rx_pipe;
  logic               rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_pipe <= '1;
    else       rx_pipe <= RX_PIPE'({rx_pipe, UART_RX});
  end
  assign rx_s = rx_pipe[RX_PIPE-1];

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  rx_state_t         rx_state, rx_state_n;
  logic [BAUD_W-1:0] rx_baud, rx_baud_n;
  logic [2:0]        rx_bit_idx, rx_bit_idx_n;
  logic [7:0]        rx_byte, rx_byte_n;
  logic [W-1:0]      rx_word, rx_word_n;
  logic [BC_W-1:0]   rx_byte_cnt, rx_byte_cnt_n;
  logic              rx_push_c, rx_bit_end_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state    <= RX_IDLE;
      rx_baud     <= '0;
      rx_bit_idx  <= '0;
      rx_byte     <= '0;
      rx_word     <= '0;
      rx_byte_cnt <= '0;
    end else begin
      rx_state    <= rx_state_n;
      rx_baud     <= rx_baud_n;
      rx_bit_idx  <= rx_bit_idx_n;
      rx_byte     <= rx_byte_n;
      rx_word     <= rx_word_n;
      rx_byte_cnt <= rx_byte_cnt_n;
    end
  end

  always_comb begin
    rx_state_n    = rx_state;
    rx_baud_n     = rx_baud;
    rx_bit_idx_n  = rx_bit_idx;
    rx_byte_n     = rx_byte;
    rx_word_n     = rx_word;
    rx_byte_cnt_n = rx_byte_cnt;
    rx_bit_end_c  = (rx_baud == BAUD_W'(BIT - 1));
    rx_push_c     = (rx_byte_cnt == BC_W'(N_BYTES));
    if (rx_push_c) rx_byte_cnt_n = '0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_baud_n  = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_baud == BAUD_W'(HALF - 1)) begin
          rx_baud_n    = '0;
          rx_bit_idx_n = '0;
          rx_state_n   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_baud_n = rx_baud + BAUD_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_bit_end_c) begin
          rx_baud_n = '0;
          rx_byte_n = {rx_s, rx_byte[7:1]};
          if (rx_bit_idx == 3'd7) rx_state_n = RX_STOP;
          else                    rx_bit_idx_n = rx_bit_idx + 3'd1;
        end else begin
          rx_baud_n = rx_baud + BAUD_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_bit_end_c) begin
          rx_baud_n = '0;
          if (rx_s) begin
            for (int k = 0; k < int'(N_BYTES); k++) begin
              if (rx_byte_cnt == BC_W'(k)) rx_word_n[8*k +: 8] = rx_byte;
            end
            rx_byte_cnt_n = rx_byte_cnt + BC_W'(1);
            rx_state_n    = RX_IDLE;
          end else begin
            rx_state_n = RX_WAIT;
          end
        end else begin
          rx_baud_n = rx_baud + BAUD_W'(1);
        end
      end
      RX_WAIT: begin
        if (rx_s) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- RX queue with registered head word ----------------
  logic [W-1:0]     rx_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] rx_wr, rx_rd, rx_rd_n_c;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n_c;
  logic             rx_wr_c, rx_pop_c;
  logic [W-1:0]     head_n_c, m_data;
  logic             m_valid;

  assign rx_wr_c    = rx_push_c && (rx_cnt != CNT_W'(QUEUE_DEPTH));
  assign rx_pop_c   = m_valid && M_AXIS_TREADY;
  assign rx_cnt_n_c = rx_cnt + CNT_W'(rx_wr_c) - CNT_W'(rx_pop_c);
  assign rx_rd_n_c  = rx_pop_c ? ptr_inc(rx_rd) : rx_rd;
  // The next head may be the slot being written this very cycle.
  assign head_n_c   = (rx_wr_c && (rx_rd_n_c == rx_wr)) ? rx_word : rx_mem[rx_rd_n_c];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr   <= '0;
      rx_rd   <= '0;
      rx_cnt  <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (rx_wr_c) rx_wr <= ptr_inc(rx_wr);
      rx_rd   <= rx_rd_n_c;
      rx_cnt  <= rx_cnt_n_c;
      m_valid <= (rx_cnt_n_c != '0);
      if (rx_cnt_n_c != '0) m_data <= head_n_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr_c) rx_mem[rx_wr] <= rx_word;
  end

  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TDATA  = m_data;

endmodule

// File: tb/tb_axis_uart_bridge_rx_tx.sv
// Directed bench for axis_uart_bridge_rx_tx with BIT=10, two-byte words, four-word queues.
module tb_axis_uart_bridge_rx_tx;

  localparam int unsigned BIT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        uart_rx;
  logic        uart_tx;
  logic        loopback;
  logic        rx_drv;

  int vecs = 0;
  int errs = 0;

  logic [7:0]  exp_tx [$];
  logic [15:0] exp_rx [$];
  logic [15:0] ovf_words [5] = '{16'hC001, 16'hC102, 16'hC203, 16'hC304, 16'hC405};

  assign uart_rx = loopback ? uart_tx : rx_drv;

  always #5 clk = ~clk;

  axis_uart_bridge_rx_tx #(
    .UART_SPEED(100000), .FREQ_HZ(1000000), .N_BYTES(2), .QUEUE_DEPTH(4),
    .QUEUE_MEMTYPE("auto"), .TX_REGISTER_LEN(1), .RX_REGISTER_LEN(1)
  ) dut (
    .clk(clk), .reset(reset),
    .S_AXIS_TDATA(s_data), .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready),
    .M_AXIS_TDATA(m_data), .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready),
    .UART_RX(uart_rx), .UART_TX(uart_tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    s_data  = w;
    s_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (s_ready) ok = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("push_accept", 32'(ok), 1);
  endtask

  // Checks one two-byte word on UART_TX sample by sample, then idle high.
  task automatic check_tx_word(input string tag);
    int          t;
    logic [7:0]  eb;
    logic [9:0]  frame;
    logic [9:0]  seen;
    logic [19:0] idle;
    t = 0;
    while (uart_tx !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_start_seen"}, 32'(t < 3000), 1);
    for (int b = 0; b < 2; b++) begin
      eb    = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'h00;
      frame = {1'b1, eb, 1'b0};
      for (int k = 0; k < 10; k++) begin
        for (int s = 0; s < int'(BIT); s++) begin
          seen[s] = uart_tx;
          @(negedge clk);
        end
        check({tag, "_bit"}, 32'(seen), 32'({10{frame[k]}}));
      end
    end
    for (int s = 0; s < 20; s++) begin
      idle[s] = uart_tx;
      @(negedge clk);
    end
    check({tag, "_idle"}, 32'(idle), 32'h000F_FFFF);
  endtask

  task automatic collect_words(input int n, input string tag);
    int got;
    int t;
    got = 0;
    t   = 0;
    while (got < n && t < 5000) begin
      if (m_valid && m_ready) begin
        check(tag, 32'(m_data), 32'(exp_rx.pop_front()));
        got++;
      end
      @(negedge clk);
      t++;
    end
    check({tag, "_count"}, 32'(got), 32'(n));
  endtask

  task automatic send_rx_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = frame[k];
      repeat (BIT) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int accepted;
    int t;
    logic [59:0] post_idle;
    reset    = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;
    loopback = 1'b0;
    rx_drv   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tready", 32'(s_ready), 0);
    check("rst_mvalid", 32'(m_valid), 0);
    check("rst_mdata", 32'(m_data), 0);
    check("rst_uart_tx", 32'(uart_tx), 1);
    reset = 1'b0;
    #1 check("tready_before_edge", 32'(s_ready), 0);
    @(negedge clk);
    check("tready_after_release", 32'(s_ready), 1);

    // Single word on the wire: 0x5A then 0xA5, LSB first.
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'hA5);
    push_word(16'hA55A);
    check_tx_word("tx_a55a");

    // Loopback keeps word order.
    loopback = 1'b1;
    exp_rx.push_back(16'h1234);
    exp_rx.push_back(16'hBEEF);
    push_word(16'h1234);
    push_word(16'hBEEF);
    collect_words(2, "loop");
    repeat (30) @(negedge clk);
    loopback = 1'b0;
    repeat (10) @(negedge clk);

    // Three-cycle low pulse is a glitch.
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (50) @(negedge clk);
    check("glitch_no_word", 32'(m_valid), 0);

    // Framing error byte is discarded.
    send_rx_byte(8'h33, 1'b0);
    repeat (20) @(negedge clk);
    exp_rx.push_back(16'h2211);
    send_rx_byte(8'h11, 1'b1);
    send_rx_byte(8'h22, 1'b1);
    collect_words(1, "frame_err");

    // Five words with no consumer: four held, fifth dropped.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_rx.push_back(ovf_words[i]);
      send_rx_byte(ovf_words[i][7:0], 1'b1);
      send_rx_byte(ovf_words[i][15:8], 1'b1);
      repeat (3) @(negedge clk);
      check("ovf_hold_valid", 32'(m_valid), 1);
      check("ovf_hold_data", 32'(m_data), 32'(ovf_words[0]));
    end
    repeat (10) @(negedge clk);
    m_ready = 1'b1;
    collect_words(4, "ovf");
    repeat (2) @(negedge clk);
    check("ovf_drained", 32'(m_valid), 0);

    // TX queue fill: four queued plus one in the shift register.
    accepted = 0;
    s_valid  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      s_data = 16'h7000 + 16'(i);
      if (s_ready) accepted++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("fill_accepted", 32'(accepted), 5);
    check("fill_tready_low", 32'(s_ready), 0);
    t = 0;
    while (!s_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("fill_reassert_seen", 32'(t < 500), 1);
    check("fill_reassert_not_early", 32'(t > 100), 1);

    // Reset in the middle of a start bit.
    t = 0;
    while (uart_tx !== 1'b0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("pre_rst_line_low", 32'(uart_tx), 0);
    reset = 1'b1;
    #1;
    check("rst_mid_uart_tx", 32'(uart_tx), 1);
    check("rst_mid_tready", 32'(s_ready), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_mvalid", 32'(m_valid), 0);
    for (int s = 0; s < 60; s++) begin
      post_idle[s] = uart_tx;
      @(negedge clk);
    end
    check("post_rst_idle", 32'(post_idle[31:0] & post_idle[59:28]), 32'hFFFF_FFFF);
    exp_tx.push_back(8'h3C);
    exp_tx.push_back(8'hC3);
    push_word(16'hC33C);
    check_tx_word("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
